serial_reg_bridge: RTL and testbench
====================================

# serial_reg_bridge

Parametrised serial host bridge between an external debug/host controller and the CPU core's register-level I/O. A host frames serial transactions selecting one of `NREGS` word registers. Every frame returns the register's current read-side value; write frames also update a host-to-core register and pulse a strobe. All logic runs on the system clock, and the serial clock is sampled as data.

## Interface
- `WIDTH`, 32: word width in bits; must be ≥ 8.
- `NREGS`, 8: number of register channels; must be ≥ 2 and need not be a power of two.
- `ADDR_W`, `$clog2(NREGS)`: width of the address field (derived).
- `clk_sys` in 1: the only clock.
- `sys_reset` in 1: reset, synchronous, active-high.
- `sclk` in 1: host serial clock, asynchronous to `clk_sys`, sampled internally.
- `frame_en` in 1: host frame enable, active-high; asynchronous, sampled internally.
- `sdi` in 1: host-to-bridge serial data, LSB first.
- `sdo` out 1: bridge-to-host serial data, LSB first.
- `rd_regs` in `NREGS*WIDTH`: core-to-host words; word k is bits [k*WIDTH +: WIDTH].
- `wr_regs` out `NREGS*WIDTH`: host-to-core words, same packing.
- `wr_strobe` out 1: one-cycle pulse when a write commits.
- `wr_addr` out `ADDR_W`: index of the last committed write.
- `frame_err` out 1: one-cycle pulse on an aborted or out-of-range frame.

## Operation
- Input conditioning: `sclk`, `frame_en` and `sdi` each pass through a 2-FF synchroniser. A registered rising-edge detect on the synchronised `sclk` produces `bit_tick`.
- Frame format, one bit per `bit_tick`: bit 0 = W (1 = write), then `ADDR_W` address bits (LSB first), then `WIDTH` data bits (LSB first).
- FSM states and transitions:
  - IDLE: moves to HDR when synchronised `frame_en` rises; bit counter cleared.
  - HDR: shifts W and address bits. On the last header tick:
    - if addr < `NREGS`, load the snapshot shift register with `rd_regs[addr]`;
    - otherwise load zero and set the internal `bad` flag.
    - Moves to DATA.
  - DATA: each tick shifts `sdi` into the data register and shifts the snapshot right. After the `WIDTH`-th tick, moves to COMMIT.
  - COMMIT: lasts one cycle. If W=1 and not `bad`: write `wr_regs[addr]`, assert `wr_strobe`, update `wr_addr`. If `bad`: assert `frame_err`. Moves to DRAIN.
  - DRAIN: ignores further ticks. Moves to IDLE when `frame_en` falls.
- Abort: `frame_en` falling in HDR or DATA → no write, `frame_err` pulse, go to IDLE.
- `sdo` = snapshot[0] in DATA; 0 in every other state.
- A write frame also returns the pre-write read-side value.
- `rd_regs` is sampled only at the snapshot instant. Later changes do not affect the frame in flight.
- Bit counter width is `$clog2(WIDTH+1)`. It never wraps within a frame.

## Timing
- Reset values: `sdo`=0, `wr_regs`=all 0, `wr_strobe`=0, `wr_addr`=0, `frame_err`=0, FSM=IDLE, synchronisers and counters cleared.
- Reset asserted mid-frame drops the frame with no strobe and no error pulse. The bridge waits for a fresh `frame_en` rise after reset.
- `bit_tick` occurs 3 `clk_sys` cycles after a `sclk` rising edge.
- Host constraint: `sclk` high ≥ 4 and low ≥ 4 `clk_sys` cycles. `sdi` must be stable for 4 cycles around each `sclk` rise.
- `sdo` bit n is valid from 1 cycle after the tick that consumed the previous bit, so it is stable before the next `sclk` rise under the host constraint.
- `wr_strobe`, `wr_regs` and `frame_err` update in the same cycle, one cycle after the final data tick.
- A `frame_en` fall in the same cycle as the final data tick counts as complete: the commit happens with no error.

## Structure
- Shared package `bridge_pkg`: FSM state enum (IDLE, HDR, DATA, COMMIT, DRAIN) and frame field offsets (W bit index, header length `1+ADDR_W`).
- Sub-module `sync_edge`: 2-FF synchroniser plus rising/falling edge outputs, instantiated for `sclk` and `frame_en`. `sdi` uses the synchroniser only.

## Test plan
- Reset: drive `sys_reset` for 2 cycles → all outputs 0 and `wr_regs`=0 immediately after.
- Write, `WIDTH`=32, `NREGS`=8: W=1, addr=3, data 0xDEADBEEF → one `wr_strobe` with `wr_addr`=3 and word 3 = 0xDEADBEEF; `sdo` returns `rd_regs` word 3 (0x12345678).
- Read: W=0, addr=5, `rd_regs` word 5 = 0xA5A5_0F0F, changed to 0 mid-frame → `sdo` shifts out 0xA5A5_0F0F; no strobe; `wr_regs` unchanged.
- Abort: `frame_en` drops after 10 data bits of a write to addr 1 → `frame_err` pulse, word 1 unchanged; the next full frame completes normally.
- Out-of-range, `NREGS`=6: write to addr 7 → `frame_err`, no strobe, `sdo` all zeros.
- Overrun and reset: 40 data bits in one frame → single commit, extra bits ignored. `sys_reset` mid-HDR → no strobe and no error; the next frame works.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states and frame layout for serial_reg_bridge
package bridge_pkg;
    typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT, DRAIN} state_t;
    localparam int W_BIT = 0;
    function automatic int hdr_len(input int addr_w);
        return 1 + addr_w;
    endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchroniser with registered rising/falling edge pulses
module sync_edge (
    input  logic clk_sys,
    input  logic sys_reset,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic s1, s3;
    always_ff @(posedge clk_sys) begin
        if (sys_reset) begin
            s1   <= 1'b0;
            lvl  <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            lvl  <= s1;
            s3   <= lvl;
            rise <= lvl & ~s3;
            fall <= ~lvl & s3;
        end
    end
endmodule

// File: rtl/serial_reg_bridge.sv
// serial_reg_bridge: serial host access to NREGS word registers; every frame returns the
// read-side word, write frames also update the host-to-core word and pulse wr_strobe
module serial_reg_bridge
    import bridge_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 8,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                   clk_sys,
    input  logic                   sys_reset,
    input  logic                   sclk,
    input  logic                   frame_en,
    input  logic                   sdi,
    output logic                   sdo,
    input  logic [NREGS*WIDTH-1:0] rd_regs,
    output logic [NREGS*WIDTH-1:0] wr_regs,
    output logic                   wr_strobe,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   frame_err
);
    localparam int HL = hdr_len(ADDR_W);
    localparam int CW = $clog2(WIDTH + 1);

    state_t            state, state_d;
    logic [1:0]        sdi_sync;
    logic              tick, sclk_lvl, sclk_fall, fe_lvl, fe_rise, fe_fall;
    logic [CW-1:0]     cnt;
    logic [HL-1:0]     hdr, hdr_full;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic              is_wr, bad, in_range;
    logic [WIDTH-1:0]  data, data_nx, snap, rd_word;
    logic              hdr_last, data_last, abort, commit;

    sync_edge u_sclk (
        .clk_sys  (clk_sys),
        .sys_reset(sys_reset),
        .din      (sclk),
        .lvl      (sclk_lvl),
        .rise     (tick),
        .fall     (sclk_fall)
    );

    sync_edge u_frame (
        .clk_sys  (clk_sys),
        .sys_reset(sys_reset),
        .din      (frame_en),
        .lvl      (fe_lvl),
        .rise     (fe_rise),
        .fall     (fe_fall)
    );

    assign hdr_full  = {sdi_sync[1], hdr[HL-1:1]};
    assign addr_nx   = hdr_full[HL-1:1];
    assign in_range  = int'(addr_nx) < NREGS;
    assign rd_word   = in_range ? rd_regs[addr_nx*WIDTH +: WIDTH] : '0;
    assign data_nx   = {sdi_sync[1], data[WIDTH-1:1]};
    assign hdr_last  = tick && cnt == CW'(HL - 1);
    assign data_last = tick && cnt == CW'(WIDTH - 1);
    assign sdo       = (state == DATA) & snap[0];

    // The final data tick wins over a simultaneous frame_en fall, so that frame commits.
    always_comb begin
        state_d = state;
        abort   = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE:    state_d = fe_rise ? HDR : IDLE;
            HDR: begin
                abort   = fe_fall;
                state_d = fe_fall ? IDLE : hdr_last ? DATA : HDR;
            end
            DATA: begin
                commit  = data_last;
                abort   = !data_last && fe_fall;
                state_d = data_last ? COMMIT : fe_fall ? IDLE : DATA;
            end
            COMMIT:  state_d = DRAIN;
            DRAIN:   state_d = fe_lvl ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commit results are registered on the final tick so strobe, word and error appear together.
    always_ff @(posedge clk_sys) begin
        if (sys_reset) begin
            state     <= IDLE;
            sdi_sync  <= '0;
            cnt       <= '0;
            hdr       <= '0;
            addr      <= '0;
            is_wr     <= 1'b0;
            bad       <= 1'b0;
            data      <= '0;
            snap      <= '0;
            wr_regs   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            sdi_sync  <= {sdi_sync[0], sdi};
            wr_strobe <= commit && is_wr && !bad;
            frame_err <= abort || (commit && bad);
            cnt       <= (state == IDLE || (state == HDR && hdr_last)) ? '0 :
                         (tick && (state == HDR || state == DATA)) ? cnt + CW'(1) : cnt;
            if (state == HDR && tick)
                hdr <= hdr_full;
            if (state == HDR && hdr_last) begin
                addr  <= addr_nx;
                is_wr <= hdr_full[W_BIT];
                bad   <= !in_range;
                snap  <= rd_word;
            end
            if (state == DATA && tick) begin
                data <= data_nx;
                snap <= snap >> 1;
            end
            if (commit && is_wr && !bad) begin
                wr_regs[addr*WIDTH +: WIDTH] <= data_nx;
                wr_addr                      <= addr;
            end
        end
    end
endmodule

// File: tb/tb_serial_reg_bridge.sv
// tb_serial_reg_bridge: one host drives an 8-channel and a 6-channel bridge; expected
// events and sdo words are queued as frames are driven and checked as the bridges respond
module tb_serial_reg_bridge;
    localparam int W = 32;

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
    } ev_t;

    logic clk_sys = 1'b0, sys_reset = 1'b0, sclk = 1'b0, frame_en = 1'b0, sdi = 1'b0;
    logic [8*W-1:0] rd;
    logic [8*W-1:0] wr8;
    logic [6*W-1:0] wr6;
    logic           sdo8, sdo6, st8, st6, err8, err6;
    logic [2:0]     wa8, wa6;
    ev_t            q8[$], q6[$];
    logic [31:0]    sdo_q8[$], sdo_q6[$];
    logic [31:0]    m8[8], m6[6];
    int             n_tests = 0, n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    serial_reg_bridge #(.WIDTH(W), .NREGS(8)) dut8 (
        .clk_sys(clk_sys), .sys_reset(sys_reset), .sclk(sclk), .frame_en(frame_en),
        .sdi(sdi), .sdo(sdo8), .rd_regs(rd), .wr_regs(wr8), .wr_strobe(st8),
        .wr_addr(wa8), .frame_err(err8)
    );

    serial_reg_bridge #(.WIDTH(W), .NREGS(6)) dut6 (
        .clk_sys(clk_sys), .sys_reset(sys_reset), .sclk(sclk), .frame_en(frame_en),
        .sdi(sdi), .sdo(sdo6), .rd_regs(rd[6*W-1:0]), .wr_regs(wr6), .wr_strobe(st6),
        .wr_addr(wa6), .frame_err(err6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        ev_t e;
        if (!sys_reset && (st8 || err8)) begin
            check("dut8 event expected", q8.size() > 0, 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("dut8 event kind", st8 ? 1 : 2, e.kind);
                if (st8) begin
                    check("dut8 wr_addr", wa8, e.addr);
                    check("dut8 word", wr8[wa8*W +: W], e.data);
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        ev_t e;
        if (!sys_reset && (st6 || err6)) begin
            check("dut6 event expected", q6.size() > 0, 1);
            if (q6.size() > 0) begin
                e = q6.pop_front();
                check("dut6 event kind", st6 ? 1 : 2, e.kind);
                if (st6) begin
                    check("dut6 wr_addr", wa6, e.addr);
                    check("dut6 word", wr6[wa6*W +: W], e.data);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic drop, output logic s8, output logic s6);
        sdi = b;
        repeat (4) @(negedge clk_sys);
        s8   = sdo8;
        s6   = sdo6;
        sclk = 1'b1;
        if (drop) frame_en = 1'b0;
        repeat (5) @(negedge clk_sys);
        sclk = 1'b0;
        repeat (5) @(negedge clk_sys);
    endtask

    // ndata < 32 aborts the frame; chg zeroes the addressed rd word after that data bit
    task automatic frame(input logic w, input int addr, input logic [31:0] data,
                         input int ndata, input int chg, input logic drop_last);
        logic [31:0] got8, got6, mask, extra;
        logic        s8, s6;
        got8  = '0;
        got6  = '0;
        extra = $urandom();
        mask  = ndata >= 32 ? '1 : (32'd1 << ndata) - 32'd1;
        sdo_q8.push_back(rd[addr*W +: W]);
        sdo_q6.push_back(addr < 6 ? rd[addr*W +: W] : 32'd0);
        if (ndata < 32) begin
            q8.push_back('{2, addr, 32'd0});
            q6.push_back('{2, addr, 32'd0});
        end else begin
            if (w) begin
                q8.push_back('{1, addr, data});
                m8[addr] = data;
            end
            if (addr >= 6) q6.push_back('{2, addr, 32'd0});
            else if (w) begin
                q6.push_back('{1, addr, data});
                m6[addr] = data;
            end
        end
        frame_en = 1'b1;
        repeat (8) @(negedge clk_sys);
        send_bit(w, 1'b0, s8, s6);
        for (int i = 0; i < 3; i++) send_bit(addr[i], 1'b0, s8, s6);
        for (int i = 0; i < ndata; i++) begin
            send_bit(i < 32 ? data[i] : extra[i-32], drop_last && i == ndata - 1, s8, s6);
            if (i < 32) begin
                got8[i] = s8;
                got6[i] = s6;
            end
            if (i == chg) rd[addr*W +: W] = '0;
        end
        frame_en = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("dut8 sdo word", got8 & mask, sdo_q8.pop_front() & mask);
        check("dut6 sdo word", got6 & mask, sdo_q6.pop_front() & mask);
    endtask

    task automatic check_idle();
        check("dut8 sdo idle", sdo8, 0);
        check("dut8 strobe idle", st8, 0);
        check("dut8 err idle", err8, 0);
        check("dut8 wr_addr idle", wa8, 0);
        check("dut8 wr_regs zero", wr8 == '0, 1);
        check("dut6 sdo idle", sdo6, 0);
        check("dut6 strobe idle", st6, 0);
        check("dut6 err idle", err6, 0);
        check("dut6 wr_addr idle", wa6, 0);
        check("dut6 wr_regs zero", wr6 == '0, 1);
    endtask

    task automatic check_words();
        for (int k = 0; k < 8; k++) check($sformatf("dut8 wr_regs[%0d]", k), wr8[k*W +: W], m8[k]);
        for (int k = 0; k < 6; k++) check($sformatf("dut6 wr_regs[%0d]", k), wr6[k*W +: W], m6[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic s8, s6;
        for (int k = 0; k < 8; k++) begin
            rd[k*W +: W] = 32'h1111_1111 * (k + 1);
            m8[k] = '0;
        end
        for (int k = 0; k < 6; k++) m6[k] = '0;
        rd[3*W +: W] = 32'h1234_5678;
        rd[5*W +: W] = 32'hA5A5_0F0F;
        sys_reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        sys_reset = 1'b0;
        check_idle();
        repeat (4) @(negedge clk_sys);

        frame(1'b1, 3, 32'hDEAD_BEEF, 32, -1, 1'b0);
        frame(1'b0, 5, 32'h0000_0000, 32, 4, 1'b0);
        frame(1'b1, 1, 32'h1357_9BDF, 10, -1, 1'b0);
        frame(1'b1, 1, 32'hCAFE_F00D, 32, -1, 1'b0);
        frame(1'b1, 7, 32'h55AA_55AA, 32, -1, 1'b0);
        frame(1'b1, 2, 32'h0BAD_C0DE, 40, -1, 1'b0);
        frame(1'b1, 4, 32'h600D_F00D, 32, -1, 1'b1);
        check_words();

        frame_en = 1'b1;
        repeat (8) @(negedge clk_sys);
        send_bit(1'b1, 1'b0, s8, s6);
        send_bit(1'b0, 1'b0, s8, s6);
        sys_reset = 1'b1;
        frame_en  = 1'b0;
        repeat (2) @(negedge clk_sys);
        sys_reset = 1'b0;
        for (int k = 0; k < 8; k++) m8[k] = '0;
        for (int k = 0; k < 6; k++) m6[k] = '0;
        check_idle();
        repeat (10) @(negedge clk_sys);

        frame(1'b1, 0, 32'h8765_4321, 32, -1, 1'b0);
        frame(1'b0, 0, 32'h0000_0000, 32, -1, 1'b0);
        check_words();
        check("dut8 pending events", q8.size(), 0);
        check("dut6 pending events", q6.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
